burst_clk_gen: RTL and testbench

- Synthesizable stimulus-clock generator for the simulation benches in this codebase; drives the clock and stop inputs of the blocks under test downstream.
- After a start pulse it produces two clock-enable-rate square waves:
  - clk_a: free-running, toggles every DIV_A cycles.
  - clk_b: finite burst of exactly BURST_N toggles, every DIV_B cycles.
- After the burst it waits TAIL cycles, then raises done, which the bench uses as its finish condition.
- The running phase has an explicit exit path, so all later states are reachable.

---
 rtl/burst_clk_gen.sv | 171 +++++++++++++++++
 tb/tb_burst_clk_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/burst_clk_gen.sv
// burst_clk_gen: stimulus clock generator.
// After a start pulse it runs a free-running divided clock (clk_a) and a
// finite burst of BURST_N toggles on clk_b, then waits TAIL cycles before
// raising done. stop returns to IDLE from any state.
//
// Optional feature macro: BURST_CLK_GATE_EN
//   defined   - clk_a freezes on entry to DONE and busy is low in DONE
//   undefined - clk_a keeps toggling in DONE and busy stays high
//
// state | meaning
// IDLE  | waiting for start, clk_a=0, clk_b=1
// BURST | clk_a running, clk_b toggling every DIV_B cycles
// TAIL  | clk_b finished, counting TAIL cycles
// DONE  | done=1 until stop or rst
module burst_clk_gen #(
  parameter int DIV_A   = 10,
  parameter int DIV_B   = 5,
  parameter int BURST_N = 50,
  parameter int TAIL    = 75,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic          clk_a,
  output logic          clk_b,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] burst_cnt
);

  // Terminal-count values; unused ones (e.g. BURST_N=0) wrap harmlessly.
  localparam logic [CW-1:0] DIV_A_LAST = CW'(DIV_A - 1);
  localparam logic [CW-1:0] DIV_B_LAST = CW'(DIV_B - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_N - 1);
  localparam logic [CW-1:0] TAIL_LAST  = CW'(TAIL - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_TAIL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_a_cnt_q, div_a_cnt_d;
  logic [CW-1:0] div_b_cnt_q, div_b_cnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CW-1:0] tail_cnt_q, tail_cnt_d;
  logic          clk_a_q, clk_a_d;
  logic          clk_b_q, clk_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          a_run;

  // Next-state, counter and output computation; stop overrides everything.
  always_comb begin
    state_d     = state_q;
    div_a_cnt_d = div_a_cnt_q;
    div_b_cnt_d = div_b_cnt_q;
    burst_cnt_d = burst_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    clk_a_d     = clk_a_q;
    clk_b_d     = clk_b_q;

`ifdef BURST_CLK_GATE_EN
    a_run = (state_q == ST_BURST) || (state_q == ST_TAIL);
`else
    a_run = (state_q != ST_IDLE);
`endif

    // clk_a phase runs continuously across BURST/TAIL(/DONE) transitions.
    if (a_run) begin
      if (div_a_cnt_q == DIV_A_LAST) begin
        div_a_cnt_d = '0;
        clk_a_d     = ~clk_a_q;
      end else begin
        div_a_cnt_d = div_a_cnt_q + CNT_ONE;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_a_cnt_d = '0;
          div_b_cnt_d = '0;
          burst_cnt_d = '0;
          tail_cnt_d  = '0;
          if (BURST_N != 0)   state_d = ST_BURST;
          else if (TAIL != 0) state_d = ST_TAIL;
          else                state_d = ST_DONE;
        end
      end
      ST_BURST: begin
        if (div_b_cnt_q == DIV_B_LAST) begin
          div_b_cnt_d = '0;
          clk_b_d     = ~clk_b_q;
          burst_cnt_d = burst_cnt_q + CNT_ONE;
          if (burst_cnt_q == BURST_LAST) begin
            tail_cnt_d = '0;
            if (TAIL != 0) state_d = ST_TAIL;
            else           state_d = ST_DONE;
          end
        end else begin
          div_b_cnt_d = div_b_cnt_q + CNT_ONE;
        end
      end
      ST_TAIL: begin
        if (tail_cnt_q == TAIL_LAST) state_d = ST_DONE;
        else                         tail_cnt_d = tail_cnt_q + CNT_ONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stop) begin
      state_d     = ST_IDLE;
      div_a_cnt_d = '0;
      div_b_cnt_d = '0;
      burst_cnt_d = '0;
      tail_cnt_d  = '0;
      clk_a_d     = 1'b0;
      clk_b_d     = 1'b1;
    end

`ifdef BURST_CLK_GATE_EN
    busy_d = (state_d == ST_BURST) || (state_d == ST_TAIL);
`else
    busy_d = (state_d != ST_IDLE);
`endif
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_a_cnt_q <= '0;
      div_b_cnt_q <= '0;
      burst_cnt_q <= '0;
      tail_cnt_q  <= '0;
      clk_a_q     <= 1'b0;
      clk_b_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_a_cnt_q <= div_a_cnt_d;
      div_b_cnt_q <= div_b_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      clk_a_q     <= clk_a_d;
      clk_b_q     <= clk_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign clk_a     = clk_a_q;
  assign clk_b     = clk_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_burst_clk_gen.sv
// Bench for burst_clk_gen: three instances with different parameter sets
// share one stimulus stream. Expected outputs come from elapsed cycles since
// the accepted start edge, using closed-form arithmetic.
module tb_burst_clk_gen;

  localparam int ND = 3;
  localparam int P_DA [ND] = '{2, 3, 2};
  localparam int P_DB [ND] = '{1, 1, 2};
  localparam int P_BN [ND] = '{4, 0, 5};
  localparam int P_TL [ND] = '{3, 0, 4};

`ifdef BURST_CLK_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clk_a_w [ND];
  logic        clk_b_w [ND];
  logic        busy_w  [ND];
  logic        done_w  [ND];
  logic [15:0] cnt_w   [ND];

  burst_clk_gen #(.DIV_A(2), .DIV_B(1), .BURST_N(4), .TAIL(3), .CW(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clk_a(clk_a_w[0]), .clk_b(clk_b_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .burst_cnt(cnt_w[0]));

  burst_clk_gen #(.DIV_A(3), .DIV_B(1), .BURST_N(0), .TAIL(0), .CW(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clk_a(clk_a_w[1]), .clk_b(clk_b_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .burst_cnt(cnt_w[1]));

  burst_clk_gen #(.DIV_A(2), .DIV_B(2), .BURST_N(5), .TAIL(4), .CW(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clk_a(clk_a_w[2]), .clk_b(clk_b_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .burst_cnt(cnt_w[2]));

  // Hand-computed values for u_dut0 at 0..7 cycles after the start edge.
  int lit_a    [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  int lit_b    [8] = '{1, 0, 1, 0, 1, 1, 1, 1};
  int lit_cnt  [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
  int lit_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit m_run    = 1'b0;
  int m_e0     = 0;
  bit chk_on   = 1'b0;
  bit lit_on   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got %0d expected %0d", name, idx, cyc, act, exp);
    end
  endtask

  // Reference: a run is in progress from an accepted start until stop/rst.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || stop) begin
      m_run <= 1'b0;
    end else if (start && !m_run) begin
      m_run <= 1'b1;
      m_e0  <= cyc + 1;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      int t;
      t = cyc - m_e0;
      for (int i = 0; i < ND; i++) begin
        int n, td, ka, e_a, e_b, e_busy, e_done;
        if (m_run) begin
          n = t / P_DB[i];
          if (n > P_BN[i]) n = P_BN[i];
          td = P_BN[i] * P_DB[i] + P_TL[i];
          if (GATED) ka = ((t < td) ? t : td) / P_DA[i];
          else       ka = t / P_DA[i];
          e_a    = ka % 2;
          e_b    = 1 - (n % 2);
          e_done = (t >= td) ? 1 : 0;
          if (GATED) e_busy = 1 - e_done;
          else       e_busy = 1;
        end else begin
          n      = 0;
          e_a    = 0;
          e_b    = 1;
          e_busy = 0;
          e_done = 0;
        end
        check("clk_a", i, int'(clk_a_w[i]), e_a);
        check("clk_b", i, int'(clk_b_w[i]), e_b);
        check("busy", i, int'(busy_w[i]), e_busy);
        check("done", i, int'(done_w[i]), e_done);
        check("burst_cnt", i, int'(cnt_w[i]), n);
      end
      if (lit_on && m_run && t < 8) begin
        check("lit_clk_a", 0, int'(clk_a_w[0]), lit_a[t]);
        check("lit_clk_b", 0, int'(clk_b_w[0]), lit_b[t]);
        check("lit_burst_cnt", 0, int'(cnt_w[0]), lit_cnt[t]);
        check("lit_done", 0, int'(done_w[0]), lit_done[t]);
        check("lit_done_zero_burst", 1, int'(done_w[1]), 1);
        check("lit_clk_b_zero_burst", 1, int'(clk_b_w[1]), 1);
      end
    end
  end

  task automatic drive(input logic s, input logic p, input logic r);
    start = s;
    stop  = p;
    rst   = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Nominal run, pinned by literal expectations.
    lit_on = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    idle(30);
    lit_on = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    idle(3);

    // Stop at E0+2, then a full restart.
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 1'b1, 1'b0);
    idle(4);
    drive(1'b1, 1'b0, 1'b0);
    idle(25);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);

    // start and stop together in IDLE.
    drive(1'b1, 1'b1, 1'b0);
    idle(20);

    // Reset at E0+3, then a fresh run with a second start while busy.
    drive(1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    idle(25);
    drive(1'b0, 1'b1, 1'b0);
    idle(2);

    // Random pulses on start, stop and rst.
    repeat (4000) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
